min_slot_bank: RTL and testbench

MIN_SLOT_BANK -- requirements
Module: min_slot_bank

---
 rtl/min_slot_bank.sv | 132 +++++++++++++
 tb/tb_min_slot_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/min_slot_bank.sv
`default_nettype none
// ============================================================================
// min_slot_bank : bank of saturating countdown slots with min-directed insert
// Rev 1.0
// ============================================================================
module min_slot_bank #(
  parameter  int N  = 8,
  parameter  int W  = 10,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  input  logic [W-1:0]     ins_data,
  output logic             ins_ready,
  input  logic             tick,
  input  logic             clr,
  input  logic [IW-1:0]    min_idx,
  output logic [N*W-1:0]   bus,
  output logic             ins_done,
  output logic [IW-1:0]    ins_slot,
  output logic [CW-1:0]    occupied
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic            ins_done_q, ins_done_d;
  logic [IW-1:0]   ins_slot_q, ins_slot_d;
  logic [W-1:0]    slot_q [N];
  logic [W-1:0]    slot_d [N];
  logic [N-1:0]    slot_nz;
  logic            changing;
  logic            write_en;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      assign slot_nz[gi]          = (slot_q[gi] != '0);
      assign bus[gi*W +: W]       = slot_q[gi];
    end
  endgenerate

  // A tick only disturbs the bus (and thus the external min result) if some slot is live.
  assign changing  = tick && (|slot_nz);
  assign write_en  = (state_q == S_WRITE);
  assign ins_ready = (state_q == S_IDLE) && !clr;

  always_comb begin
    occupied = '0;
    for (int i = 0; i < N; i++) begin
      occupied = occupied + CW'(slot_nz[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ins_done_d = 1'b0;
    ins_slot_d = ins_slot_q;
    case (state_q)
      S_IDLE: begin
        if (ins_valid && ins_ready) begin
          data_d  = ins_data;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!changing) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ins_done_d = 1'b1;
        ins_slot_d = min_idx;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (clr) begin
      state_d    = S_IDLE;
      ins_done_d = 1'b0;
      ins_slot_d = ins_slot_q;
    end
  end

  // Clear beats the insert write, which beats the saturating decrement.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      slot_d[i] = slot_q[i];
      if (clr) begin
        slot_d[i] = '0;
      end else if (write_en && (IW'(i) == min_idx)) begin
        slot_d[i] = data_q;
      end else if (tick && slot_nz[i]) begin
        slot_d[i] = slot_q[i] - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      ins_done_q <= 1'b0;
      ins_slot_q <= '0;
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      ins_done_q <= ins_done_d;
      ins_slot_q <= ins_slot_d;
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign ins_done = ins_done_q;
  assign ins_slot = ins_slot_q;

endmodule
`default_nettype wire

// File: tb/tb_min_slot_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_min_slot_bank : scoreboard bench with an ideal lowest-index min block
// Rev 1.0
// ============================================================================
module tb_min_slot_bank;
  localparam int N = 8;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ins_valid = 1'b0;
  logic [W-1:0]   ins_data = '0;
  logic           tick = 1'b0;
  logic           clr = 1'b0;
  logic [2:0]     min_idx;
  logic           ins_ready;
  logic [N*W-1:0] bus;
  logic           ins_done;
  logic [2:0]     ins_slot;
  logic [3:0]     occupied;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int           slot;
    int           lat;
    logic [W-1:0] val;
  } exp_t;
  exp_t sb[$];

  min_slot_bank #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_data(ins_data),
    .ins_ready(ins_ready), .tick(tick), .clr(clr), .min_idx(min_idx),
    .bus(bus), .ins_done(ins_done), .ins_slot(ins_slot), .occupied(occupied)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External min block: smallest value, lowest index on ties.
  always_comb begin
    automatic int b = 0;
    for (int i = 1; i < N; i++) begin
      if (bus[i*W +: W] < bus[b*W +: W]) b = i;
    end
    min_idx = 3'(b);
  end

  function automatic logic [W-1:0] slot(input int i);
    return bus[i*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ins_valid = 1'b0; tick = 1'b0; clr = 1'b0; ins_data = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // tick_off: cycle offset from the request cycle at which tick is pulsed (-1 = none)
  task automatic do_insert(input string nm, input logic [W-1:0] v, input int exp_slot,
                           input int exp_lat, input int tick_off, input logic busy_valid);
    exp_t e;
    int   t0;
    bit   seen;
    checks++;
    if (ins_ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready: got %b want 1", nm, ins_ready);
    end
    sb.push_back('{exp_slot, exp_lat, v});
    t0 = cyc; ins_valid = 1'b1; ins_data = v; tick = (tick_off == 0);
    step();
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      ins_valid = busy_valid; ins_data = busy_valid ? 10'd77 : '0; tick = (k == tick_off);
      step();
      if (ins_done === 1'b1) seen = 1'b1;
    end
    ins_valid = 1'b0; tick = 1'b0; ins_data = '0;
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      failures++; $display("FAIL %s_done: got no pulse want pulse within 20 cycles", nm);
    end else begin
      if (ins_slot !== 3'(e.slot)) begin
        failures++; $display("FAIL %s_slot: got %0d want %0d", nm, ins_slot, e.slot);
      end
      checks++;
      if (cyc - t0 != e.lat) begin
        failures++; $display("FAIL %s_latency: got %0d want %0d", nm, cyc - t0, e.lat);
      end
      checks++;
      if (slot(e.slot) !== e.val) begin
        failures++; $display("FAIL %s_value: got %0d want %0d", nm, slot(e.slot), e.val);
      end
    end
  endtask

  task automatic expect_no_done(input string nm, input int ncyc);
    bit bad = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      step();
      if (ins_done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL %s_no_done: got pulse want none", nm);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus !== '0) begin failures++; $display("FAIL rst_bus: got %h want 0", bus); end
    checks++; if (ins_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", ins_ready); end
    checks++; if (ins_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", ins_done); end
    checks++; if (ins_slot !== 3'd0) begin failures++; $display("FAIL rst_slot: got %0d want 0", ins_slot); end
    checks++; if (occupied !== 4'd0) begin failures++; $display("FAIL rst_occ: got %0d want 0", occupied); end
    do_reset();
  endtask

  task automatic test_single_insert();
    do_reset();
    do_insert("single", 10'd5, 0, 3, -1, 1'b0);
    checks++; if (occupied !== 4'd1) begin failures++; $display("FAIL single_occ: got %0d want 1", occupied); end
    step();
    checks++; if (ins_done !== 1'b0) begin failures++; $display("FAIL single_pulse: got %b want 0", ins_done); end
    checks++; if (ins_slot !== 3'd0) begin failures++; $display("FAIL single_hold: got %0d want 0", ins_slot); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) begin
      do_insert("fill", 10'(10 * (i + 1)), i, 3, -1, 1'b0);
    end
    checks++; if (occupied !== 4'd8) begin failures++; $display("FAIL fill_occ: got %0d want 8", occupied); end
    do_insert("overwrite", 10'd7, 0, 3, -1, 1'b0);
    checks++; if (occupied !== 4'd8) begin failures++; $display("FAIL ovw_occ: got %0d want 8", occupied); end
    checks++; if (slot(1) !== 10'd20) begin failures++; $display("FAIL ovw_s1: got %0d want 20", slot(1)); end
  endtask

  task automatic test_saturate();
    do_reset();
    do_insert("sat_a", 10'd3, 0, 3, -1, 1'b0);
    do_insert("sat_b", 10'd1, 1, 3, -1, 1'b0);
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if (slot(0) !== 10'd2 || slot(1) !== 10'd0 || occupied !== 4'd1) begin
      failures++; $display("FAIL sat_t1: got s0=%0d s1=%0d occ=%0d want 2 0 1", slot(0), slot(1), occupied);
    end
    for (int k = 0; k < 2; k++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    checks++;
    if (bus !== '0 || occupied !== 4'd0) begin
      failures++; $display("FAIL sat_t3: got bus=%h occ=%0d want 0 0", bus, occupied);
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (bus !== '0) begin failures++; $display("FAIL sat_wrap: got %h want 0", bus); end
  endtask

  task automatic test_tick_settle();
    do_reset();
    do_insert("ts_pre", 10'd4, 0, 3, -1, 1'b0);
    do_insert("ts", 10'd9, 1, 4, 1, 1'b0);
    checks++; if (slot(0) !== 10'd3) begin failures++; $display("FAIL ts_s0: got %0d want 3", slot(0)); end
  endtask

  task automatic test_tick_write();
    do_reset();
    do_insert("tw_a", 10'd4, 0, 3, -1, 1'b0);
    do_insert("tw_b", 10'd6, 1, 3, -1, 1'b0);
    do_insert("tw", 10'd9, 2, 3, 2, 1'b0);
    checks++;
    if (slot(0) !== 10'd3 || slot(1) !== 10'd5) begin
      failures++; $display("FAIL tw_others: got %0d %0d want 3 5", slot(0), slot(1));
    end
  endtask

  task automatic test_busy_ignored();
    do_reset();
    do_insert("busy", 10'd5, 0, 3, -1, 1'b1);
    expect_no_done("busy", 5);
    checks++;
    if (occupied !== 4'd1 || ins_ready !== 1'b1) begin
      failures++; $display("FAIL busy_state: got occ=%0d ready=%b want 1 1", occupied, ins_ready);
    end
  endtask

  task automatic test_clr_abort();
    do_reset();
    do_insert("clr_pre", 10'd4, 0, 3, -1, 1'b0);
    ins_valid = 1'b1; ins_data = 10'd9; step(); ins_valid = 1'b0;
    clr = 1'b1; #1;
    checks++; if (ins_ready !== 1'b0) begin failures++; $display("FAIL clr_ready_low: got %b want 0", ins_ready); end
    step(); clr = 1'b0; #1;
    checks++;
    if (bus !== '0 || ins_ready !== 1'b1 || ins_done !== 1'b0) begin
      failures++; $display("FAIL clr_after: got bus=%h ready=%b done=%b want 0 1 0", bus, ins_ready, ins_done);
    end
    expect_no_done("clr", 6);
  endtask

  task automatic test_reset_abort();
    do_reset();
    do_insert("ra_pre", 10'd4, 0, 3, -1, 1'b0);
    ins_valid = 1'b1; ins_data = 10'd9; step(); ins_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    checks++;
    if (bus !== '0 || ins_ready !== 1'b1 || occupied !== 4'd0 || ins_done !== 1'b0) begin
      failures++; $display("FAIL ra_async: got bus=%h ready=%b occ=%0d done=%b want 0 1 0 0", bus, ins_ready, occupied, ins_done);
    end
    step(); #2 rst_n = 1'b1;
    expect_no_done("ra", 6);
    checks++; if (ins_ready !== 1'b1) begin failures++; $display("FAIL ra_ready: got %b want 1", ins_ready); end
  endtask

  initial begin
    test_reset();
    test_single_insert();
    test_back_to_back();
    test_saturate();
    test_tick_settle();
    test_tick_write();
    test_busy_ignored();
    test_clr_abort();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
